// File: rtl/tag_array_nway_if.sv
// Bus between the data-cache controller (master) and the N-way tag array (slave).
// Optional TAG_ARRAY_PERF_EN adds the hit/miss counter outputs.
interface tag_array_nway_if #(
  parameter int TAG_BITS   = 5,
  parameter int INDEX_BITS = 3,
  parameter int WAYS       = 4
);
  localparam int WAY_BITS = $clog2(WAYS);

  logic [INDEX_BITS-1:0] i_index;
  logic [TAG_BITS-1:0]   i_tag;
  logic                  i_lookup;
  logic                  i_fill;
  logic                  i_invalidate;
  logic                  i_modify;
  logic                  i_reserve_exclusive;
  logic                  i_flush_all;
  logic                  o_hit;
  logic [WAY_BITS-1:0]   o_hit_way;
  logic [1:0]            o_hit_state;
  logic [WAY_BITS-1:0]   o_victim_way;
  logic [TAG_BITS+1:0]   o_victim_entry;
  logic                  o_victim_dirty;
  logic                  o_busy;
`ifdef TAG_ARRAY_PERF_EN
  logic [31:0]           o_hit_count;
  logic [31:0]           o_miss_count;
`endif

  modport master (
    output i_index, i_tag, i_lookup, i_fill, i_invalidate, i_modify,
           i_reserve_exclusive, i_flush_all,
    input  o_hit, o_hit_way, o_hit_state, o_victim_way, o_victim_entry,
           o_victim_dirty, o_busy
`ifdef TAG_ARRAY_PERF_EN
    , input o_hit_count, o_miss_count
`endif
  );

  modport slave (
    input  i_index, i_tag, i_lookup, i_fill, i_invalidate, i_modify,
           i_reserve_exclusive, i_flush_all,
    output o_hit, o_hit_way, o_hit_state, o_victim_way, o_victim_entry,
           o_victim_dirty, o_busy
`ifdef TAG_ARRAY_PERF_EN
    , output o_hit_count, o_miss_count
`endif
  );
endinterface

// File: rtl/tag_array_nway.sv
// N-way set-associative tag array: per-line MESI state, true-LRU ages,
// combinational lookup/victim, and a one-set-per-cycle flush sweep.
// Optional macro TAG_ARRAY_PERF_EN adds saturating hit/miss lookup counters.
//
// state    | meaning
// ST_IDLE  | normal operation, lookups/fills/state ops accepted
// ST_SWEEP | flush in progress, set cnt_q cleared each cycle, all ops ignored
module tag_array_nway #(
  parameter int TAG_BITS   = 5,
  parameter int INDEX_BITS = 3,
  parameter int WAYS       = 4
) (
  input logic             clk,
  input logic             rst,
  tag_array_nway_if.slave bus
);
  localparam int WAY_BITS = $clog2(WAYS);
  localparam int NUM_SETS = 1 << INDEX_BITS;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_M = 2'b10;
  localparam logic [1:0] MESI_E = 2'b11;

  logic [TAG_BITS-1:0] tag_q   [NUM_SETS][WAYS];
  logic [1:0]          state_q [NUM_SETS][WAYS];
  logic [WAY_BITS-1:0] age_q   [NUM_SETS][WAYS];

  logic [0:0]            fsm_q;
  logic [INDEX_BITS-1:0] cnt_q;

  logic                busy;
  logic                hit_raw;
  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic                inv_found;
  logic [WAY_BITS-1:0] inv_way;
  logic [WAY_BITS-1:0] lru_way;
  logic [WAY_BITS-1:0] victim_way;
  logic                accept;
  logic                do_fill;
  logic                do_touch;
  logic                do_state;
  logic [WAY_BITS-1:0] fill_way;
  logic [WAY_BITS-1:0] touch_way;
  logic [WAY_BITS-1:0] touch_age;
  logic [1:0]          next_state;

  assign busy = (fsm_q == ST_SWEEP);

  // Tag compare over the addressed set; descending scan so the lowest match wins.
  always_comb begin
    hit_raw = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (state_q[bus.i_index][w] != MESI_I && tag_q[bus.i_index][w] == bus.i_tag) begin
        hit_raw = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  // Victim: lowest invalid way, else the way whose age is LRU.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (state_q[bus.i_index][w] == MESI_I) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
      if (age_q[bus.i_index][w] == WAY_BITS'(WAYS - 1)) lru_way = WAY_BITS'(w);
    end
    victim_way = inv_found ? inv_way : lru_way;
  end

  assign hit = hit_raw && !busy;

  // Operation decode; a fill wins over state ops and touches only once.
  always_comb begin
    accept    = (fsm_q == ST_IDLE) && !bus.i_flush_all;
    fill_way  = hit ? hit_way : victim_way;
    do_fill   = accept && bus.i_fill;
    do_touch  = do_fill || (accept && bus.i_lookup && hit);
    touch_way = do_fill ? fill_way : hit_way;
    touch_age = age_q[bus.i_index][touch_way];
    do_state  = accept && !bus.i_fill && hit &&
                (bus.i_invalidate || bus.i_modify || bus.i_reserve_exclusive);
    if (bus.i_invalidate)  next_state = MESI_I;
    else if (bus.i_modify) next_state = MESI_M;
    else                   next_state = MESI_E;
  end

  // Array, LRU and flush sequencer updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
      cnt_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]   <= '0;
          state_q[s][w] <= MESI_I;
          age_q[s][w]   <= WAY_BITS'(w);
        end
      end
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (bus.i_flush_all) begin
            fsm_q <= ST_SWEEP;
            cnt_q <= '0;
          end
        end
        default: begin
          for (int w = 0; w < WAYS; w++) begin
            state_q[cnt_q][w] <= MESI_I;
            age_q[cnt_q][w]   <= WAY_BITS'(w);
          end
          if (cnt_q == INDEX_BITS'(NUM_SETS - 1)) begin
            fsm_q <= ST_IDLE;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase

      if (do_fill) begin
        tag_q[bus.i_index][fill_way]   <= bus.i_tag;
        state_q[bus.i_index][fill_way] <= MESI_S;
      end else if (do_state) begin
        state_q[bus.i_index][hit_way] <= next_state;
      end

      if (do_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_BITS'(w) == touch_way)
            age_q[bus.i_index][w] <= '0;
          else if (age_q[bus.i_index][w] < touch_age)
            age_q[bus.i_index][w] <= age_q[bus.i_index][w] + 1'b1;
        end
      end
    end
  end

  assign bus.o_busy         = busy;
  assign bus.o_hit          = hit;
  assign bus.o_hit_way      = hit ? hit_way : '0;
  assign bus.o_hit_state    = hit ? state_q[bus.i_index][hit_way] : MESI_I;
  assign bus.o_victim_way   = victim_way;
  assign bus.o_victim_entry = {state_q[bus.i_index][victim_way], tag_q[bus.i_index][victim_way]};
  assign bus.o_victim_dirty = (state_q[bus.i_index][victim_way] == MESI_M);

`ifdef TAG_ARRAY_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating lookup counters, idle cycles only.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (bus.i_lookup && !busy) begin
      if (hit_raw) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign bus.o_hit_count  = hit_cnt_q;
  assign bus.o_miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_tag_array_nway.sv
// Directed bench for tag_array_nway with an expected-value queue.
module tb_tag_array_nway;
  logic clk;
  logic rst;

  tag_array_nway_if #(.TAG_BITS(5), .INDEX_BITS(3), .WAYS(4)) bus ();

  tag_array_nway #(.TAG_BITS(5), .INDEX_BITS(3), .WAYS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string nm, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    assert (obs === e.val) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", e.name, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    bus.i_lookup            = 1'b0;
    bus.i_fill              = 1'b0;
    bus.i_invalidate        = 1'b0;
    bus.i_modify            = 1'b0;
    bus.i_reserve_exclusive = 1'b0;
    bus.i_flush_all         = 1'b0;
  endtask

  // ops = {lookup, fill, invalidate, modify, reserve_exclusive, flush_all}
  task automatic op(input logic [2:0] idx, input logic [4:0] tag, input logic [5:0] ops);
    bus.i_index = idx;
    bus.i_tag   = tag;
    {bus.i_lookup, bus.i_fill, bus.i_invalidate, bus.i_modify,
     bus.i_reserve_exclusive, bus.i_flush_all} = ops;
    tick();
    clear_ops();
  endtask

  task automatic probe(input logic [2:0] idx, input logic [4:0] tag);
    clear_ops();
    bus.i_index = idx;
    bus.i_tag   = tag;
    #1;
  endtask

  task automatic expect_hit(input string nm, input logic h, input logic [1:0] w, input logic [1:0] st);
    push({nm, "_hit"}, 32'(h));
    push({nm, "_way"}, 32'(w));
    push({nm, "_state"}, 32'(st));
    cmp(32'(bus.o_hit));
    cmp(32'(bus.o_hit_way));
    cmp(32'(bus.o_hit_state));
  endtask

  task automatic expect_victim(input string nm, input logic [1:0] w, input logic [6:0] ent, input logic d);
    push({nm, "_vway"}, 32'(w));
    push({nm, "_ventry"}, 32'(ent));
    push({nm, "_vdirty"}, 32'(d));
    cmp(32'(bus.o_victim_way));
    cmp(32'(bus.o_victim_entry));
    cmp(32'(bus.o_victim_dirty));
  endtask

  localparam logic [5:0] OP_LOOKUP = 6'b100000;
  localparam logic [5:0] OP_FILL   = 6'b010000;
  localparam logic [5:0] OP_INV    = 6'b001000;
  localparam logic [5:0] OP_MOD    = 6'b000100;
  localparam logic [5:0] OP_REX    = 6'b000010;
  localparam logic [5:0] OP_FLUSH  = 6'b000001;

  initial begin
    int n;
    rst = 1'b1;
    bus.i_index = '0;
    bus.i_tag   = '0;
    clear_ops();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    probe(3'd2, 5'h00);
    push("rst_busy", 32'd0);
    cmp(32'(bus.o_busy));
    expect_hit("rst", 1'b0, 2'd0, 2'b00);
    expect_victim("rst", 2'd0, 7'h00, 1'b0);

    // Fill four ways of set 2; ages end as [3,2,1,0]
    op(3'd2, 5'h01, OP_FILL);
    op(3'd2, 5'h02, OP_FILL);
    op(3'd2, 5'h03, OP_FILL);
    op(3'd2, 5'h04, OP_FILL);
    probe(3'd2, 5'h03);
    expect_hit("fill_t3", 1'b1, 2'd2, 2'b01);
    probe(3'd2, 5'h04);
    expect_hit("fill_t4", 1'b1, 2'd3, 2'b01);
    expect_victim("fill_lru", 2'd0, 7'h21, 1'b0);

    // Touch way 0 -> ages [0,3,2,1], victim way 1
    op(3'd2, 5'h01, OP_LOOKUP);
    probe(3'd2, 5'h01);
    expect_hit("touch0", 1'b1, 2'd0, 2'b01);
    expect_victim("touch0", 2'd1, 7'h22, 1'b0);
    op(3'd2, 5'h05, OP_FILL);
    probe(3'd2, 5'h02);
    expect_hit("evict_t2", 1'b0, 2'd0, 2'b00);
    probe(3'd2, 5'h05);
    expect_hit("fill_t5", 1'b1, 2'd1, 2'b01);

    // Touch ways 1,0,3 -> ages [1,2,3,0], way 2 LRU; modify way 2
    op(3'd2, 5'h05, OP_LOOKUP);
    op(3'd2, 5'h01, OP_LOOKUP);
    op(3'd2, 5'h04, OP_LOOKUP);
    op(3'd2, 5'h03, OP_MOD);
    probe(3'd2, 5'h03);
    expect_hit("mod_t3", 1'b1, 2'd2, 2'b10);
    expect_victim("mod_t3", 2'd2, 7'h43, 1'b1);

    // Invalidate beats modify
    op(3'd2, 5'h03, OP_INV | OP_MOD);
    probe(3'd2, 5'h03);
    expect_hit("inv_t3", 1'b0, 2'd0, 2'b00);
    expect_victim("inv_t3", 2'd2, 7'h03, 1'b0);

    // Refill into way 2 (ages [2,3,0,1]), then fill again while hitting
    op(3'd2, 5'h03, OP_FILL);
    op(3'd2, 5'h03, OP_FILL);
    probe(3'd2, 5'h03);
    expect_hit("refill_t3", 1'b1, 2'd2, 2'b01);
    probe(3'd2, 5'h05);
    expect_hit("nodup_t5", 1'b1, 2'd1, 2'b01);
    expect_victim("nodup", 2'd1, 7'h25, 1'b0);

    // State op on miss is ignored
    op(3'd2, 5'h1F, OP_MOD);
    probe(3'd2, 5'h1F);
    expect_hit("miss_mod", 1'b0, 2'd0, 2'b00);
    expect_victim("miss_mod", 2'd1, 7'h25, 1'b0);

    // Lookup + reserve_exclusive on way 3 -> ages [2,3,1,0]
    op(3'd2, 5'h04, OP_LOOKUP | OP_REX);
    probe(3'd2, 5'h04);
    expect_hit("rex_t4", 1'b1, 2'd3, 2'b11);
    push("rex_vway", 32'd1);
    cmp(32'(bus.o_victim_way));

    // Another set, so the flush has more than one set to clear
    op(3'd5, 5'h0A, OP_FILL);
    probe(3'd5, 5'h0A);
    expect_hit("set5", 1'b1, 2'd0, 2'b01);

    // Flush sweep: busy for exactly 8 cycles, hits suppressed meanwhile
    op(3'd2, 5'h05, OP_FLUSH);
    bus.i_index  = 3'd2;
    bus.i_tag    = 5'h05;
    bus.i_lookup = 1'b1;
    bus.i_fill   = 1'b1;
    #1;
    push("sweep_busy", 32'd1);
    cmp(32'(bus.o_busy));
    push("sweep_hit", 32'd0);
    cmp(32'(bus.o_hit));
    n = 0;
    while (bus.o_busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    clear_ops();
    push("busy_cycles", 32'd8);
    cmp(32'(n));
    probe(3'd2, 5'h05);
    expect_hit("post_flush_t5", 1'b0, 2'd0, 2'b00);
    probe(3'd5, 5'h0A);
    expect_hit("post_flush_set5", 1'b0, 2'd0, 2'b00);
    for (int s = 0; s < 8; s++) begin
      probe(3'(s), 5'h00);
      push($sformatf("flush_vway_s%0d", s), 32'd0);
      cmp(32'(bus.o_victim_way));
      push($sformatf("flush_vstate_s%0d", s), 32'd0);
      cmp(32'(bus.o_victim_entry[6:5]));
    end

    // Reset on sweep cycle 3 aborts the sweep and clears tags
    op(3'd4, 5'h07, OP_FILL);
    probe(3'd4, 5'h07);
    expect_hit("pre_rst_set4", 1'b1, 2'd0, 2'b01);
    op(3'd0, 5'h00, OP_FLUSH);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push("rst_abort_busy", 32'd0);
    cmp(32'(bus.o_busy));
    probe(3'd4, 5'h07);
    expect_hit("rst_abort_set4", 1'b0, 2'd0, 2'b00);
    expect_victim("rst_abort_set4", 2'd0, 7'h00, 1'b0);
    tick();
    push("rst_abort_busy_later", 32'd0);
    cmp(32'(bus.o_busy));

    // Perf counters: 3 hits, 2 misses since reset
    op(3'd1, 5'h09, OP_FILL);
    op(3'd1, 5'h09, OP_LOOKUP);
    op(3'd1, 5'h09, OP_LOOKUP);
    op(3'd1, 5'h1E, OP_LOOKUP);
    op(3'd1, 5'h09, OP_LOOKUP);
    op(3'd1, 5'h1E, OP_LOOKUP);
    probe(3'd1, 5'h09);
    expect_hit("perf_set1", 1'b1, 2'd0, 2'b01);
`ifdef TAG_ARRAY_PERF_EN
    push("hit_count", 32'd3);
    cmp(bus.o_hit_count);
    push("miss_count", 32'd2);
    cmp(bus.o_miss_count);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
